sample_ring_buffer: RTL
=======================

SAMPLE_RING_BUFFER -- requirements
Module: sample_ring_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 24, sample width in bits (signed two's complement).
REQ-002 SHALL have parameter DEPTH, default 128, buffer entries; power of two, at least 8.
REQ-003 SHALL have parameter PREFILL, default 64, level required before playback starts or resumes; 1 <= PREFILL <= DEPTH-2.
REQ-004 SHALL have parameter CLK_DIV, default 521, clk cycles per output sample (50 MHz / 521 gives about 96 kHz); at least 2.
REQ-005 SHALL have port clk, input, 1 bit: system clock; the only clock.
REQ-006 SHALL have port n_rst, input, 1 bit: synchronous reset, active-low.
REQ-007 SHALL have port i_sample, input, DATA_W bits: mixed sample from the mixer.
REQ-008 SHALL have port i_valid, input, 1 bit: i_sample is valid this cycle.
REQ-009 SHALL have port i_flush, input, 1 bit: synchronous buffer clear.
REQ-010 SHALL have port o_clk_en, output, 1 bit: pipeline enable to bank_manager/mixer; high means space is available.
REQ-011 SHALL have port o_dac_sample, output, DATA_W bits: sample presented to dac_dsm2_top din.
REQ-012 SHALL have port o_sample_stb, output, 1 bit: one-cycle pulse when o_dac_sample updates from the buffer.
REQ-013 SHALL have port o_level, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-014 SHALL have port o_playing, output, 1 bit: high in state PLAY.
REQ-015 SHALL have port o_overflow, output, 1 bit: sticky; a write was dropped.
REQ-016 SHALL have port o_underrun_cnt, output, 16 bits: count of underrun events, saturating.

Function
REQ-017 SHALL implement a ring buffer with wr_ptr and rd_ptr, each clog2(DEPTH) bits, wrapping DEPTH-1 to 0 with no special case.
REQ-018 SHALL store i_sample at wr_ptr and increment wr_ptr when i_valid=1 and level<DEPTH; when i_valid=1 and level==DEPTH, SHALL discard the sample, leave wr_ptr unchanged, and set o_overflow.
REQ-019 SHALL drive o_clk_en from a register: 1 when the next-cycle level is <= DEPTH-3, else 0; this gives a two-entry margin for mixer latency.
REQ-020 SHALL run a tick counter from 0 to CLK_DIV-1 and wrap to 0; tick is asserted in the cycle the count equals CLK_DIV-1; the counter is free-running in all states.
REQ-021 SHALL implement FSM state PREFILL: o_dac_sample=0 and no reads; go to PLAY in the first cycle level>=PREFILL.
REQ-022 SHALL implement FSM state PLAY: on tick with level>0, register mem[rd_ptr] into o_dac_sample, increment rd_ptr, and pulse o_sample_stb in the following cycle together with the new value.
REQ-023 In PLAY, on tick with level==0, SHALL go to UNDERRUN, increment o_underrun_cnt (saturating at 0xFFFF), hold o_dac_sample, and not pulse o_sample_stb.
REQ-024 SHALL implement FSM state UNDERRUN: hold o_dac_sample and do no reads; go to PLAY when level>=PREFILL; the first read occurs on the next tick.
REQ-025 On a simultaneous write and read in one cycle, SHALL leave level unchanged and advance both pointers.
REQ-026 SHALL have i_flush take priority over writes and reads in the same cycle: pointers=0, level=0, state=PREFILL, o_dac_sample=0, o_clk_en=1 next cycle.
REQ-027 i_flush SHALL NOT clear o_overflow, o_underrun_cnt or the tick counter.
REQ-028 SHALL have latency from tick to updated o_dac_sample and o_sample_stb of exactly 1 clk.
REQ-029 SHALL NOT allow o_dac_sample to change in any cycle other than an o_sample_stb cycle, flush, or reset.

Reset
REQ-030 When n_rst=0 at a clk edge, SHALL set: pointers=0, level=0, tick count=0, state=PREFILL, o_dac_sample=0, o_sample_stb=0, o_playing=0, o_overflow=0, o_underrun_cnt=0, o_clk_en=1.
REQ-031 SHALL have reset asserted mid-operation override all other activity in that cycle; i_valid is ignored while n_rst=0.

Verification (DEPTH=8, PREFILL=4, CLK_DIV=4, DATA_W=24)
REQ-032 SHALL test prefill: write 1,2,3 and wait 20 cycles -> o_playing=0, o_dac_sample=0; write 4 -> o_playing=1; the following ticks output 1,2,3,4 in order, each with a one-cycle o_sample_stb.
REQ-033 SHALL test backpressure and overflow: hold i_valid=1 with no ticks consumed -> o_clk_en falls after level reaches 6; a forced ninth write while level=8 -> dropped, o_overflow=1, level stays 8.
REQ-034 SHALL test underrun: reach PLAY with 4 samples and stop writing -> after the 4th read, the next tick gives o_underrun_cnt=1, o_dac_sample holds 4, o_playing=0; write 4 more -> resume with the first new sample on the next tick.
REQ-035 SHALL test wrap-around: stream 40 samples, values 0..39, at one per tick -> output sequence 0..39 with no gaps or duplicates after pointers wrap 5 times.
REQ-036 SHALL test flush plus simultaneous write: i_flush=1 with i_valid=1 at level 5 -> next cycle level=0, o_dac_sample=0, state PREFILL, o_underrun_cnt unchanged.
REQ-037 SHALL test reset mid-PLAY: n_rst=0 for 1 cycle at level 3 -> every output equals its REQ-030 value the following cycle.

Source files
------------

// File: rtl/sample_ring_buffer.sv
// Playback ring buffer between mixer and DAC: fills to PREFILL, then pops one sample per CLK_DIV tick.
// Tick-to-output latency 1 clk; o_clk_en drops with two entries of slack and writes at full are dropped.
module sample_ring_buffer #(
  parameter int DATA_W  = 24,
  parameter int DEPTH   = 128,
  parameter int PREFILL = 64,
  parameter int CLK_DIV = 521
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [DATA_W-1:0]      i_sample,
  input  logic                   i_valid,
  input  logic                   i_flush,
  output logic                   o_clk_en,
  output logic [DATA_W-1:0]      o_dac_sample,
  output logic                   o_sample_stb,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_playing,
  output logic                   o_overflow,
  output logic [15:0]            o_underrun_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(CLK_DIV);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_PRE   = LW'(PREFILL);
  localparam logic [LW-1:0] LVL_HI    = LW'(DEPTH - 3);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

  typedef enum logic [1:0] {ST_PREFILL, ST_PLAY, ST_UNDERRUN} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic              wr_en;
  logic              rd_en;
  logic [LW-1:0]     level_nxt;

  assign tick  = (tick_cnt == TICK_LAST);
  assign wr_en = i_valid && (o_level != LVL_FULL);
  assign rd_en = (state == ST_PLAY) && tick && (o_level != '0);

  always_comb begin
    level_nxt = o_level;
    if (wr_en && !rd_en)
      level_nxt = o_level + LW'(1);
    else if (rd_en && !wr_en)
      level_nxt = o_level - LW'(1);
  end

  // Sample-rate divider keeps running through flush so the DAC cadence never jitters.
  always_ff @(posedge clk) begin
    if (!n_rst)
      tick_cnt <= '0;
    else if (tick)
      tick_cnt <= '0;
    else
      tick_cnt <= tick_cnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (n_rst && !i_flush && wr_en)
      mem[wr_ptr] <= i_sample;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_level        <= '0;
      state          <= ST_PREFILL;
      o_dac_sample   <= '0;
      o_sample_stb   <= 1'b0;
      o_playing      <= 1'b0;
      o_overflow     <= 1'b0;
      o_underrun_cnt <= '0;
      o_clk_en       <= 1'b1;
    end else if (i_flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_level      <= '0;
      state        <= ST_PREFILL;
      o_dac_sample <= '0;
      o_sample_stb <= 1'b0;
      o_playing    <= 1'b0;
      o_clk_en     <= 1'b1;
    end else begin
      o_sample_stb <= 1'b0;
      o_level      <= level_nxt;
      o_clk_en     <= (level_nxt <= LVL_HI);
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (i_valid && !wr_en)
        o_overflow <= 1'b1;
      if (rd_en) begin
        rd_ptr       <= rd_ptr + AW'(1);
        o_dac_sample <= mem[rd_ptr];
        o_sample_stb <= 1'b1;
      end
      case (state)
        ST_PREFILL, ST_UNDERRUN: begin
          if (o_level >= LVL_PRE) begin
            state     <= ST_PLAY;
            o_playing <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (tick && (o_level == '0)) begin
            state     <= ST_UNDERRUN;
            o_playing <= 1'b0;
            if (o_underrun_cnt != 16'hFFFF)
              o_underrun_cnt <= o_underrun_cnt + 16'd1;
          end
        end
        default: begin
          state     <= ST_PREFILL;
          o_playing <= 1'b0;
        end
      endcase
    end
  end
endmodule
